reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file, the successor to the lab-2 two-read/one-write register file. It adds:
- a configurable number of read ports, data width and depth;
- optional write-to-read bypass and a hard-wired zero register;
- an asynchronous clear;
- a per-register busy scoreboard for the pipelined CPU's hazard unit.

It sits between decode (read ports, busy query) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth DEPTH = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports; 0: reads return stored value only
- ZERO_REG, 1, 1: register 0 reads 0 and ignores writes and busy-set

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- rf_ra  in  NRD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rf_rd  out  NRD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W]
- rf_busy  out  NRD  busy flag of the register addressed by read port i
- rf_we  in  1  write enable
- rf_wa  in  ADDR_W  write address
- rf_wd  in  DATA_W  write data
- sb_set  in  1  mark register sb_wa busy (a producer has been issued)
- sb_wa  in  ADDR_W  scoreboard set address
- dbg_ra  in  ADDR_W  debug read address
- dbg_rd  out  DATA_W  debug read data (stored value, never bypassed)

## Operation
- Storage: DEPTH x DATA_W registers, plus DEPTH busy bits.
- Reset (rstn=0): all registers and busy bits clear to 0 immediately, independent of clk, and held while rstn=0.
  - With no write in progress, rf_rd, rf_busy and dbg_rd all read 0 during reset.
  - With a write in progress, BYPASS=1 can still forward wd on rf_rd, since read paths stay combinational.
- Write: at a rising edge with rf_we=1, reg[rf_wa] <= rf_wd.
  - With ZERO_REG=1 and rf_wa=0, the write is dropped.
- Read port i is combinational:
  - ZERO_REG=1 and ra_i=0 → 0.
  - Else BYPASS=1, rf_we=1 and rf_wa==ra_i → rf_wd.
  - Else reg[ra_i].
- Busy bit update at a rising edge, per register k:
  - Set when sb_set=1 and sb_wa==k.
  - Else clear when rf_we=1 and rf_wa==k.
  - Else hold.
  - Set wins over clear on the same register in the same cycle: the new producer supersedes the retiring one.
- Busy is never set for k=0 when ZERO_REG=1.
- rf_busy[i] is combinational:
  - 0 if BYPASS=1 and the same-cycle write matches ra_i, because the value is forwarded.
  - Else busy[ra_i].
  - Forced 0 for register 0 when ZERO_REG=1.
- Multiple read ports addressing the same register all return identical data and busy.

## Timing
- Write latency: 1 edge. Without bypass, data is visible on rf_rd and dbg_rd in the cycle after the edge.
- Bypass latency: 0 cycles (combinational path rf_wd → rf_rd).
- Scoreboard: sb_set at edge n → rf_busy=1 from cycle n+1. A write at edge m clears busy, so rf_busy=0 from cycle m+1.
- Reset is asynchronous on assertion. Deassertion is synchronised outside the block, so the first edge after rstn rises may carry a write.
- Reset mid-write: if rstn falls in the same cycle as rf_we=1, the register holds 0 after the edge.
- No reads or outputs are registered. The only sequential elements are the register array and busy bits.

## Test plan
- Reset clears state. Preload reg3=0x12345678 and busy5=1. Pulse rstn=0 for 3 ns between edges, with rf_we=0 and no edge during the pulse.
  - Immediately: rf_rd[0] at ra=3 → 0.
  - rf_busy at ra=5 → 0.
  - dbg_rd at ra=3 → 0.
- Write/read with BYPASS=1. At t=12 ns drive we=1, wa=3, wd=0x12345678, ra0=3.
  - rf_rd[0]=0x12345678 before the edge.
  - dbg_rd(3)=0 before the edge and 0x12345678 after it.
- BYPASS=0 build with the same stimulus.
  - rf_rd[0]=0 until the edge, 0x12345678 after.
- Zero register. Write wa=0, wd=0x87654321, and sb_set with sb_wa=0.
  - rf_rd at ra=0 → 0 forever.
  - rf_busy → 0.
- Scoreboard.
  - sb_set, sb_wa=7 at edge n → rf_busy=1 for ra=7 from n+1.
  - At edge m, sb_set=1 and we=1 both on reg 7 → busy stays 1 (set wins). The data write still lands, reading 0x87654321.
  - A write alone at edge m+1 → busy 0.
- NRD=4 instance. All four ports addressing reg 2 after writing 0xA5A5A5A5.
  - All four rf_rd = 0xA5A5A5A5.
  - Distinct addresses 1..4 return their own distinct preloaded values.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus between decode/writeback (master) and the multi-port register file (slave).
// Bundles the read ports, the write port, the scoreboard set port and the debug read port.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) ();
  // No valid/ready handshake: rf_we and sb_set are single-cycle strobes sampled on every
  // rising edge and always accepted, and all read ports answer combinationally in the same cycle.
  logic [NRD*ADDR_W-1:0] rf_ra;
  logic [NRD*DATA_W-1:0] rf_rd;
  logic [NRD-1:0]        rf_busy;
  logic                  rf_we;
  logic [ADDR_W-1:0]     rf_wa;
  logic [DATA_W-1:0]     rf_wd;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_wa;
  logic [ADDR_W-1:0]     dbg_ra;
  logic [DATA_W-1:0]     dbg_rd;

  modport master (
    output rf_ra, rf_we, rf_wa, rf_wd, sb_set, sb_wa, dbg_ra,
    input  rf_rd, rf_busy, dbg_rd
  );

  modport slave (
    input  rf_ra, rf_we, rf_wa, rf_wd, sb_set, sb_wa, dbg_ra,
    output rf_rd, rf_busy, dbg_rd
  );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with optional write bypass, hard-wired zero register
// and a per-register busy scoreboard for the pipeline hazard unit.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           rstn,
  reg_file_mp_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_W;

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("reg_file_mp: NRD must be in 1..4");
  end

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic wr_eff;
  logic sb_eff;

  // Register 0 swallows both writes and busy-set when it is hard-wired to zero.
  assign wr_eff = rf.rf_we  && !((ZERO_REG != 0) && (rf.rf_wa == '0));
  assign sb_eff = rf.sb_set && !((ZERO_REG != 0) && (rf.sb_wa == '0));

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      regs_d[k] = regs_q[k];
      busy_d[k] = busy_q[k];
      if (wr_eff && (rf.rf_wa == ADDR_W'(k))) begin
        regs_d[k] = rf.rf_wd;
      end
      // A newly issued producer supersedes the one retiring on the same register.
      if (sb_eff && (rf.sb_wa == ADDR_W'(k))) begin
        busy_d[k] = 1'b1;
      end else if (wr_eff && (rf.rf_wa == ADDR_W'(k))) begin
        busy_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
      busy_q <= busy_d;
    end
  end

  logic [NRD*DATA_W-1:0] rd_all;
  logic [NRD-1:0]        busy_all;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit;
    logic              byp_hit;

    assign ra       = rf.rf_ra[gi*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = (BYPASS != 0) && rf.rf_we && (rf.rf_wa == ra);

    // A forwarded value is available now, so the hazard unit must not see it as busy.
    assign rd_all[gi*DATA_W +: DATA_W] = zero_hit ? '0 :
                                         byp_hit  ? rf.rf_wd : regs_q[ra];
    assign busy_all[gi] = !zero_hit && !byp_hit && busy_q[ra];
  end

  assign rf.rf_rd   = rd_all;
  assign rf.rf_busy = busy_all;
  assign rf.dbg_rd  = regs_q[rf.dbg_ra];
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three builds (bypass/2 ports, no bypass/2 ports, bypass/4 ports)
// share one stimulus stream and are checked against an array-level reference model.
module tb_reg_file_mp;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        sb;
  logic [4:0]  sbwa;
  logic [4:0]  dbgra;
  logic [4:0]  ra [4];

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_a ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) if_b ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NRD(4)) if_c ();

  assign if_a.rf_ra = {ra[1], ra[0]};
  assign if_b.rf_ra = {ra[1], ra[0]};
  assign if_c.rf_ra = {ra[3], ra[2], ra[1], ra[0]};
  assign if_a.rf_we = we;    assign if_b.rf_we = we;    assign if_c.rf_we = we;
  assign if_a.rf_wa = wa;    assign if_b.rf_wa = wa;    assign if_c.rf_wa = wa;
  assign if_a.rf_wd = wd;    assign if_b.rf_wd = wd;    assign if_c.rf_wd = wd;
  assign if_a.sb_set = sb;   assign if_b.sb_set = sb;   assign if_c.sb_set = sb;
  assign if_a.sb_wa = sbwa;  assign if_b.sb_wa = sbwa;  assign if_c.sb_wa = sbwa;
  assign if_a.dbg_ra = dbgra; assign if_b.dbg_ra = dbgra; assign if_c.dbg_ra = dbgra;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1), .ZERO_REG(1))
    u_a (.clk(clk), .rstn(rstn), .rf(if_a));
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0), .ZERO_REG(1))
    u_b (.clk(clk), .rstn(rstn), .rf(if_b));
  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4), .BYPASS(1), .ZERO_REG(1))
    u_c (.clk(clk), .rstn(rstn), .rf(if_c));

  // ---------------- reference model ----------------
  logic [31:0] mem [32];
  bit          bsy [32];

  function automatic void model_clear();
    for (int k = 0; k < 32; k++) begin
      mem[k] = '0;
      bsy[k] = 1'b0;
    end
  endfunction

  // Retire first, then issue: a producer issued in the same cycle stays outstanding.
  function automatic void model_edge();
    if (!rstn) begin
      model_clear();
    end else begin
      if (we && wa != 0) mem[wa] = wd;
      if (we) bsy[wa] = 1'b0;
      if (sb && sbwa != 0) bsy[sbwa] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && wa == a) return 1'b0;
    return bsy[a];
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("a_rd%0d", i),   if_a.rf_rd[i*32 +: 32], exp_rd(ra[i], 1'b1));
      chk($sformatf("a_busy%0d", i), {31'b0, if_a.rf_busy[i]}, {31'b0, exp_busy(ra[i], 1'b1)});
      chk($sformatf("b_rd%0d", i),   if_b.rf_rd[i*32 +: 32], exp_rd(ra[i], 1'b0));
      chk($sformatf("b_busy%0d", i), {31'b0, if_b.rf_busy[i]}, {31'b0, exp_busy(ra[i], 1'b0)});
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_rd%0d", i),   if_c.rf_rd[i*32 +: 32], exp_rd(ra[i], 1'b1));
      chk($sformatf("c_busy%0d", i), {31'b0, if_c.rf_busy[i]}, {31'b0, exp_busy(ra[i], 1'b1)});
    end
    chk("a_dbg", if_a.dbg_rd, mem[dbgra]);
    chk("b_dbg", if_b.dbg_rd, mem[dbgra]);
    chk("c_dbg", if_c.dbg_rd, mem[dbgra]);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; sb = 1'b0; sbwa = '0;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    idle();
    dbgra = 5'd3;
    set_ra(5'd3, 5'd5, 5'd0, 5'd1);
    model_clear();

    @(negedge clk);
    check_all();
    chk("rst_rd", if_a.rf_rd[31:0], 32'h0);
    rstn = 1'b1;

    // Preload reg3 and busy5, then an async reset pulse between edges.
    we = 1'b1; wa = 5'd3; wd = 32'h12345678; sb = 1'b1; sbwa = 5'd5;
    cycle();
    idle();
    cycle();
    chk("pre_rd3",   if_a.rf_rd[31:0], 32'h12345678);
    chk("pre_busy5", {31'b0, if_a.rf_busy[1]}, 32'h1);
    #1 rstn = 1'b0;
    model_clear();
    #3;
    chk("rst_pulse_rd3",   if_a.rf_rd[31:0], 32'h0);
    chk("rst_pulse_busy5", {31'b0, if_a.rf_busy[1]}, 32'h0);
    chk("rst_pulse_dbg3",  if_a.dbg_rd, 32'h0);
    check_all();
    rstn = 1'b1;
    @(negedge clk);

    // Bypass vs stored-only read of the same write.
    we = 1'b1; wa = 5'd3; wd = 32'h12345678; set_ra(5'd3, 5'd3, 5'd3, 5'd3); dbgra = 5'd3;
    #1;
    chk("byp_rd_pre",   if_a.rf_rd[31:0], 32'h12345678);
    chk("nobyp_rd_pre", if_b.rf_rd[31:0], 32'h0);
    chk("dbg_pre",      if_a.dbg_rd, 32'h0);
    cycle();
    idle();
    #1;
    chk("byp_rd_post",   if_a.rf_rd[31:0], 32'h12345678);
    chk("nobyp_rd_post", if_b.rf_rd[31:0], 32'h12345678);
    chk("dbg_post",      if_a.dbg_rd, 32'h12345678);
    @(negedge clk);

    // Zero register ignores writes and busy-set.
    we = 1'b1; wa = 5'd0; wd = 32'h87654321; sb = 1'b1; sbwa = 5'd0;
    set_ra(5'd0, 5'd0, 5'd0, 5'd0); dbgra = 5'd0;
    cycle();
    idle();
    cycle();
    chk("zero_rd",   if_a.rf_rd[31:0], 32'h0);
    chk("zero_busy", {31'b0, if_a.rf_busy[0]}, 32'h0);
    chk("zero_dbg",  if_a.dbg_rd, 32'h0);

    // Scoreboard: set, set-wins-over-clear, then plain clear.
    set_ra(5'd7, 5'd7, 5'd7, 5'd7); dbgra = 5'd7;
    sb = 1'b1; sbwa = 5'd7;
    cycle();
    idle();
    #1 chk("sb_set_busy", {31'b0, if_a.rf_busy[0]}, 32'h1);
    @(negedge clk);
    sb = 1'b1; sbwa = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'h87654321;
    cycle();
    idle();
    #1;
    chk("sb_win_busy", {31'b0, if_a.rf_busy[0]}, 32'h1);
    chk("sb_win_rd",   if_a.rf_rd[31:0], 32'h87654321);
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h87654321;
    cycle();
    idle();
    #1 chk("sb_clr_busy", {31'b0, if_a.rf_busy[0]}, 32'h0);
    @(negedge clk);

    // Four ports on one register, then four distinct registers.
    we = 1'b1; wa = 5'd2; wd = 32'hA5A5A5A5; set_ra(5'd2, 5'd2, 5'd2, 5'd2);
    cycle();
    idle();
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("c_same%0d", i), if_c.rf_rd[i*32 +: 32], 32'hA5A5A5A5);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      we = 1'b1; wa = 5'(k); wd = 32'h11110000 + 32'(k);
      cycle();
    end
    idle();
    set_ra(5'd1, 5'd2, 5'd3, 5'd4);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("c_dist%0d", i), if_c.rf_rd[i*32 +: 32], 32'h11110001 + 32'(i));
    @(negedge clk);

    // Reset asserted alongside a write: bypass still forwards, the register stays 0.
    we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF; set_ra(5'd9, 5'd9, 5'd9, 5'd9); dbgra = 5'd9;
    rstn = 1'b0;
    model_clear();
    #1;
    chk("rstw_byp",   if_a.rf_rd[31:0], 32'hDEADBEEF);
    chk("rstw_nobyp", if_b.rf_rd[31:0], 32'h0);
    cycle();
    rstn = 1'b1;
    idle();
    #1 chk("rstw_dbg", if_a.dbg_rd, 32'h0);
    @(negedge clk);

    // Randomised traffic on a narrow address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom_range(0, 1));
      wa    = 5'($urandom_range(0, 7));
      wd    = $urandom;
      sb    = ($urandom_range(0, 3) == 0);
      sbwa  = 5'($urandom_range(0, 7));
      dbgra = 5'($urandom_range(0, 7));
      for (int i = 0; i < 4; i++) ra[i] = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
